// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Latency: n/a (types, widths, address field helpers only).
// Backpressure: n/a.
// Contents: geometry parameters, derived field widths, FSM state encodings,
// address field extract/compose helpers.
package dcache_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LINES  = 16;
  localparam int WORDS  = 4;

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - WORD_W - OFF_W;

  // FSM encodings kept as plain constants so the state register stays a vector.
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL    = 2'd2;

  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [DATA_W-1:0]             data_t;
  typedef logic [TAG_W-1:0]              tag_t;
  typedef logic [IDX_W-1:0]              idx_t;
  typedef logic [WORD_W-1:0]             word_t;
  typedef logic [WORDS-1:0][DATA_W-1:0]  line_t;

  function automatic tag_t get_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t get_idx(input addr_t a);
    return a[OFF_W+WORD_W +: IDX_W];
  endfunction

  function automatic word_t get_word(input addr_t a);
    return a[OFF_W +: WORD_W];
  endfunction

  // Word-aligned beat address built from its fields.
  function automatic addr_t beat_addr(input tag_t t, input idx_t i, input word_t w);
    return {t, i, w, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// CPU-side request/response and memory-side beat port of the data cache.
// Latency: n/a (signal bundle only).
// Backpressure: CPU side via stall, memory side via mem_ready per beat.
// Ports: MemRead/MemWrite/cpu_addr/cpu_wdata in, cpu_rdata/hit/dirty/stall out;
// mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in (cache view).
interface dcache_if;
  import dcache_pkg::*;

  logic  MemRead;
  logic  MemWrite;
  addr_t cpu_addr;
  data_t cpu_wdata;
  data_t cpu_rdata;
  logic  hit;
  logic  dirty;
  logic  stall;
  logic  mem_req;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;
  logic  mem_ready;

  // Cache side.
  modport slave (
    input  MemRead, MemWrite, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, hit, dirty, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Pipeline + memory side.
  modport master (
    output MemRead, MemWrite, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, hit, dirty, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Latency: combinational read of the indexed line; writes land at the clock edge.
// Backpressure: none, always accepts a write.
// Ports: clk, rst (sync, clears valid/dirty); i_idx read+write index;
// o_valid/o_dirty/o_tag/o_line read data; i_we_word/i_word/i_wdata word write;
// i_we_meta/i_tag/i_valid/i_dirty metadata write (may coincide with a word write).
module dcache_array
  import dcache_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  idx_t  i_idx,
  output logic  o_valid,
  output logic  o_dirty,
  output tag_t  o_tag,
  output line_t o_line,
  input  logic  i_we_word,
  input  word_t i_word,
  input  data_t i_wdata,
  input  logic  i_we_meta,
  input  tag_t  i_tag,
  input  logic  i_valid,
  input  logic  i_dirty
);
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  tag_t             r_tag  [LINES];
  line_t            r_data [LINES];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we_meta) begin
      r_valid[i_idx] <= i_valid;
      r_dirty[i_idx] <= i_dirty;
    end
  end

  // Tags and data carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (i_we_meta) r_tag[i_idx] <= i_tag;
    if (i_we_word) r_data[i_idx][i_word] <= i_wdata;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller.
// Latency: hits are combinational (0 cycles); misses run writeback/refill bursts.
// Backpressure: stall to the pipeline on any miss; each memory beat waits on mem_ready.
// Ports: clk, rst (sync active-high); bus (dcache_if.slave) carrying the CPU
// request/response and the single-beat memory port.
module dcache_ctrl
  import dcache_pkg::*;
(
  input logic      clk,
  input logic      rst,
  dcache_if.slave  bus
);
  logic [1:0] r_state;
  word_t      r_beat;
  idx_t       r_idx;
  tag_t       r_tag;

  logic  w_req;
  tag_t  w_in_tag;
  idx_t  w_in_idx;
  word_t w_in_word;
  idx_t  w_arr_idx;
  logic  w_valid;
  logic  w_dirty;
  tag_t  w_tag;
  line_t w_line;
  logic  w_hit;
  logic  w_last;
  logic  w_we_word;
  word_t w_word_sel;
  data_t w_wdata;
  logic  w_we_meta;
  tag_t  w_meta_tag;
  logic  w_meta_dirty;

  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_in_tag  = get_tag(bus.cpu_addr);
  assign w_in_idx  = get_idx(bus.cpu_addr);
  assign w_in_word = get_word(bus.cpu_addr);

  // Outside IDLE the request must be held, but the latched index is authoritative.
  assign w_arr_idx = (r_state == IDLE) ? w_in_idx : r_idx;

  dcache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_arr_idx),
    .o_valid   (w_valid),
    .o_dirty   (w_dirty),
    .o_tag     (w_tag),
    .o_line    (w_line),
    .i_we_word (w_we_word & ~rst),
    .i_word    (w_word_sel),
    .i_wdata   (w_wdata),
    .i_we_meta (w_we_meta & ~rst),
    .i_tag     (w_meta_tag),
    .i_valid   (1'b1),
    .i_dirty   (w_meta_dirty)
  );

  assign w_hit  = (r_state == IDLE) & w_req & w_valid & (w_tag == w_in_tag);
  assign w_last = bus.mem_ready & (r_beat == word_t'(WORDS - 1));

  assign bus.hit       = w_hit;
  assign bus.dirty     = w_valid & w_dirty;
  assign bus.stall     = (r_state == IDLE) ? (w_req & ~w_hit) : 1'b1;
  assign bus.cpu_rdata = (bus.MemRead & w_hit) ? w_line[w_in_word] : '0;

  // Memory port is decoded from state so mem_req cannot glitch inside a burst.
  always_comb begin
    w_we_word     = 1'b0;
    w_word_sel    = w_in_word;
    w_wdata       = bus.cpu_wdata;
    w_we_meta     = 1'b0;
    w_meta_tag    = w_tag;
    w_meta_dirty  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      IDLE: begin
        // Store hit: word and dirty bit update together.
        if (w_hit & bus.MemWrite) begin
          w_we_word    = 1'b1;
          w_we_meta    = 1'b1;
          w_meta_dirty = 1'b1;
        end
      end
      WRITEBACK: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = beat_addr(w_tag, r_idx, r_beat);
        bus.mem_wdata = w_line[r_beat];
        // Line stays valid under its old tag, now clean.
        w_we_meta     = w_last;
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = beat_addr(r_tag, r_idx, r_beat);
        w_we_word    = bus.mem_ready;
        w_word_sel   = r_beat;
        w_wdata      = bus.mem_rdata;
        w_we_meta    = w_last;
        w_meta_tag   = r_tag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_idx   <= '0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req & ~w_hit) begin
            r_idx   <= w_in_idx;
            r_tag   <= w_in_tag;
            r_beat  <= '0;
            r_state <= (w_valid & w_dirty) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) r_beat <= r_beat + word_t'(1);
          if (w_last) r_state <= REFILL;
        end
        REFILL: begin
          if (bus.mem_ready) r_beat <= r_beat + word_t'(1);
          if (w_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected memory beats and load data are
// queued by the stimulus; a monitor pops and compares them as the DUT presents them.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_if bus();

  dcache_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wd;
  } beat_t;

  beat_t       mem_q[$];
  logic [63:0] cpu_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Backing memory contents: each word is tagged with its own address.
  function automatic logic [63:0] pat(input logic [31:0] a);
    return {32'hCAFE_0000, a};
  endfunction

  assign bus.mem_rdata = pat(bus.mem_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic push_rd_line(input logic [31:0] base);
    for (int i = 0; i < WORDS; i++) begin
      beat_t b;
      b.we = 1'b0; b.addr = base + 32'(8 * i); b.wd = 64'h0;
      mem_q.push_back(b);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [63:0] d);
    beat_t b;
    b.we = 1'b1; b.addr = a; b.wd = d;
    mem_q.push_back(b);
  endtask

  // Monitor: compares every accepted memory beat and every completed load.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_req && bus.mem_ready) begin
        if (mem_q.size() == 0) begin
          chk("mem_beat_unexpected", {32'h0, bus.mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = mem_q.pop_front();
          chk("mem_we", {63'h0, bus.mem_we}, {63'h0, e.we});
          chk("mem_addr", {32'h0, bus.mem_addr}, {32'h0, e.addr});
          if (e.we) chk("mem_wdata", bus.mem_wdata, e.wd);
        end
      end
      if (!rst && bus.MemRead && !bus.MemWrite && !bus.stall) begin
        if (cpu_q.size() == 0) chk("cpu_rd_unexpected", bus.cpu_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
      end
    end
  end

  // Issue one request, hold it until stall drops, then check the completion cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [63:0] exp_rd,
                        input logic exp_dirty, input int exp_stall, input string nm);
    int   n;
    logic done;
    logic d0;
    n = 0; done = 1'b0; d0 = 1'b0;
    if (rd && !wr) cpu_q.push_back(exp_rd);
    @(posedge clk); #1;
    bus.MemRead = rd; bus.MemWrite = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 0) d0 = bus.dirty;
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      n++;
    end
    chk({nm, " done"}, {63'h0, done}, 64'h1);
    chk({nm, " stall_cycles"}, 64'(n), 64'(exp_stall));
    chk({nm, " dirty"}, {63'h0, d0}, {63'h0, exp_dirty});
    chk({nm, " hit"}, {63'h0, bus.hit}, 64'h1);
    chk({nm, " mem_req_idle"}, {63'h0, bus.mem_req}, 64'h0);
    @(posedge clk); #1;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
  endtask

  // Holds mem_ready low for three cycles on beat 2 of the 0x2200 refill.
  task automatic hold_ready();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 32'h2208) begin
        found = 1'b1;
        break;
      end
    end
    chk("hold found_beat1", {63'h0, found}, 64'h1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold mem_addr", {32'h0, bus.mem_addr}, 64'h2210);
      chk("hold stall", {63'h0, bus.stall}, 64'h1);
      chk("hold mem_req", {63'h0, bus.mem_req}, 64'h1);
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    logic found;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req",   {63'h0, bus.mem_req}, 64'h0);
    chk("rst mem_we",    {63'h0, bus.mem_we}, 64'h0);
    chk("rst mem_addr",  {32'h0, bus.mem_addr}, 64'h0);
    chk("rst mem_wdata", bus.mem_wdata, 64'h0);
    chk("rst cpu_rdata", bus.cpu_rdata, 64'h0);
    chk("rst hit",       {63'h0, bus.hit}, 64'h0);
    chk("rst dirty",     {63'h0, bus.dirty}, 64'h0);
    chk("rst stall",     {63'h0, bus.stall}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold read: miss cycle + 4 refill beats, then hit with beat-0 data.
    push_rd_line(32'h100);
    do_req(1'b1, 1'b0, 32'h100, 64'h0, pat(32'h100), 1'b0, WORDS + 1, "cold_rd");

    // Read hit in the refilled line.
    do_req(1'b1, 1'b0, 32'h108, 64'h0, pat(32'h108), 1'b0, 0, "hit_rd");

    // Store hit, then the line reports dirty and returns the stored word.
    do_req(1'b0, 1'b1, 32'h110, 64'hDEAD, 64'h0, 1'b0, 0, "st_hit");
    do_req(1'b1, 1'b0, 32'h110, 64'h0, 64'hDEAD, 1'b1, 0, "rd_dead");

    // Conflict miss on the dirty line: 4 writebacks, 4 refills.
    push_wr(32'h100, pat(32'h100));
    push_wr(32'h108, pat(32'h108));
    push_wr(32'h110, 64'hDEAD);
    push_wr(32'h118, pat(32'h118));
    push_rd_line(32'h1100);
    do_req(1'b1, 1'b0, 32'h1100, 64'h0, pat(32'h1100), 1'b1, 2 * WORDS + 1, "dirty_miss");

    // Refilled line is clean.
    do_req(1'b1, 1'b0, 32'h1108, 64'h0, pat(32'h1108), 1'b0, 0, "after_wb");

    // mem_ready low for 3 cycles on refill beat 2.
    push_rd_line(32'h2200);
    fork
      do_req(1'b1, 1'b0, 32'h2200, 64'h0, pat(32'h2200), 1'b0, WORDS + 4, "ready_low");
      hold_ready();
    join

    // Reset during refill beat 1 aborts the burst.
    push_rd_line(32'h3300);
    void'(mem_q.pop_back());
    void'(mem_q.pop_back());
    @(posedge clk); #1;
    bus.MemRead = 1'b1; bus.cpu_addr = 32'h3300;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_addr == 32'h3308) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid found_beat1", {63'h0, found}, 64'h1);
    #2;
    rst = 1'b1;
    bus.MemRead = 1'b0;
    @(negedge clk);
    chk("rst_mid mem_req", {63'h0, bus.mem_req}, 64'h0);
    chk("rst_mid stall",   {63'h0, bus.stall}, 64'h0);
    chk("rst_mid hit",     {63'h0, bus.hit}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Every line was invalidated: 0x100 misses and refills again.
    push_rd_line(32'h100);
    do_req(1'b1, 1'b0, 32'h100, 64'h0, pat(32'h100), 1'b0, WORDS + 1, "reread");

    repeat (3) @(negedge clk);
    chk("mem_q drained", 64'(mem_q.size()), 64'h0);
    chk("cpu_q drained", 64'(cpu_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
